// File: rtl/contador_pkg.sv
// Shared definitions for the contador counter controller: FSM state encoding and run modes.
package contador_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/contador_core.sv
// Counter register: synchronous clear has priority over increment, wraps modulo 2^WIDTH.
module contador_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = value_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/contador_ctrl.sv
// Counter controller: IDLE/RUN FSM, config registers locked during a run, one-shot or auto-reload.
// Define CONTADOR_CTRL_PRESCALE_EN to add cfg_presc and a tick prescaler (tick every presc+1 cycles).
module contador_ctrl
  import contador_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_we,
  input  logic [WIDTH-1:0]   cfg_limit,
  input  logic               cfg_mode,
`ifdef CONTADOR_CTRL_PRESCALE_EN
  input  logic [PRESC_W-1:0] cfg_presc,
`endif
  output logic               busy,
  output logic [WIDTH-1:0]   count,
  output logic               done
);

  if (PRESC_W < 1) begin : g_presc_w_chk
    $error("PRESC_W must be at least 1");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] limit_q;
  logic             mode_q;
  logic             done_q, done_d;
  logic             busy_q;
  logic             clr, inc;
  logic             tick;
  logic             at_limit;
  logic             cfg_open;

  assign at_limit = (count == limit_q);
  assign cfg_open = (state_q == IDLE) && cfg_we;

`ifdef CONTADOR_CTRL_PRESCALE_EN
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] presc_cnt_q;

  assign tick = (presc_cnt_q == presc_q);

  // Divider restarts on every tick, on abort, and whenever the FSM is idle (covers start).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      presc_cnt_q <= '0;
    end else begin
      if (cfg_open) presc_q <= cfg_presc;
      if (state_q != RUN || stop || tick) begin
        presc_cnt_q <= '0;
      end else begin
        presc_cnt_q <= presc_cnt_q + PRESC_W'(1);
      end
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      limit_q <= '1;
      mode_q  <= MODE_ONESHOT;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= done_d;
      if (cfg_open) begin
        limit_q <= cfg_limit;
        mode_q  <= cfg_mode;
      end
    end
  end

  // Stop always wins over start and over a coincident terminal tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start && !stop) state_d = RUN;
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tick && at_limit && mode_q == MODE_ONESHOT) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    clr    = 1'b0;
    inc    = 1'b0;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: clr = start && !stop;
      RUN: begin
        if (!stop && tick) begin
          if (at_limit) begin
            done_d = 1'b1;
            clr    = (mode_q == MODE_RELOAD);
          end else begin
            inc = 1'b1;
          end
        end
      end
    endcase
  end

  contador_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (inc),
    .value(count)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_contador_ctrl.sv
// Directed self-checking bench for contador_ctrl; prescaler scenario built with CONTADOR_CTRL_PRESCALE_EN.
module tb_contador_ctrl;

  localparam int WIDTH   = 8;
  localparam int PRESC_W = 4;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               stop;
  logic               cfg_we;
  logic [WIDTH-1:0]   cfg_limit;
  logic               cfg_mode;
`ifdef CONTADOR_CTRL_PRESCALE_EN
  logic [PRESC_W-1:0] cfg_presc;
`endif
  logic               busy;
  logic [WIDTH-1:0]   count;
  logic               done;

  int checks;
  int errors;

  contador_ctrl #(
    .WIDTH  (WIDTH),
    .PRESC_W(PRESC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .cfg_we   (cfg_we),
    .cfg_limit(cfg_limit),
    .cfg_mode (cfg_mode),
`ifdef CONTADOR_CTRL_PRESCALE_EN
    .cfg_presc(cfg_presc),
`endif
    .busy     (busy),
    .count    (count),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [WIDTH-1:0] lim, input logic mode);
    cfg_we    = 1'b1;
    cfg_limit = lim;
    cfg_mode  = mode;
    step();
    cfg_we    = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({busy, done, count} !== {1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b count=%0d expected busy=0 done=0 count=0", busy, done, count);
    end
    #14 rst_n = 1'b1;
    step();
    // Reset limit is all ones and mode one-shot: full 0..255 run.
    do_start();
    checks++;
    if ({busy, done, count} !== {1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL default_start: busy=%b done=%b count=%0d expected busy=1 done=0 count=0", busy, done, count);
    end
    repeat (255) step();
    checks++;
    if ({busy, done, count} !== {1'b1, 1'b0, 8'd255}) begin
      errors++;
      $display("FAIL default_at_max: busy=%b done=%b count=%0d expected busy=1 done=0 count=255", busy, done, count);
    end
    step();
    checks++;
    if ({busy, done, count} !== {1'b0, 1'b1, 8'd255}) begin
      errors++;
      $display("FAIL default_done: busy=%b done=%b count=%0d expected busy=0 done=1 count=255", busy, done, count);
    end
  endtask

  task automatic test_oneshot();
    write_cfg(8'd5, 1'b0);
    do_start();
    checks++;
    if ({busy, done, count} !== {1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL oneshot_start: busy=%b done=%b count=%0d expected busy=1 done=0 count=0", busy, done, count);
    end
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if ({busy, done, count} !== {1'b1, 1'b0, 8'(i)}) begin
        errors++;
        $display("FAIL oneshot_run: busy=%b done=%b count=%0d expected busy=1 done=0 count=%0d", busy, done, count, i);
      end
    end
    step();
    checks++;
    if ({busy, done, count} !== {1'b0, 1'b1, 8'd5}) begin
      errors++;
      $display("FAIL oneshot_done: busy=%b done=%b count=%0d expected busy=0 done=1 count=5", busy, done, count);
    end
    step();
    checks++;
    if ({busy, done, count} !== {1'b0, 1'b0, 8'd5}) begin
      errors++;
      $display("FAIL oneshot_hold: busy=%b done=%b count=%0d expected busy=0 done=0 count=5", busy, done, count);
    end
  endtask

  task automatic test_reload();
    write_cfg(8'd3, 1'b1);
    do_start();
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if ({busy, done, count} !== {1'b1, (k % 4 == 0), 8'(k % 4)}) begin
        errors++;
        $display("FAIL reload_seq k=%0d: busy=%b done=%b count=%0d expected busy=1 done=%b count=%0d",
                 k, busy, done, count, (k % 4 == 0), k % 4);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if ({busy, done, count} !== {1'b0, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL reload_stop: busy=%b done=%b count=%0d expected busy=0 done=0 count=2", busy, done, count);
    end
  endtask

  task automatic test_stop_priority();
    write_cfg(8'd9, 1'b0);
    do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if ({busy, done, count} !== {1'b1, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL start_in_run: busy=%b done=%b count=%0d expected busy=1 done=0 count=2", busy, done, count);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if ({busy, done, count} !== {1'b0, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL stop_abort: busy=%b done=%b count=%0d expected busy=0 done=0 count=2", busy, done, count);
    end
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    step();
    checks++;
    if ({busy, done, count} !== {1'b0, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL start_stop_idle: busy=%b done=%b count=%0d expected busy=0 done=0 count=2", busy, done, count);
    end
    // Stop coinciding with the terminal tick suppresses done.
    write_cfg(8'd2, 1'b1);
    do_start();
    step();
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if ({busy, done, count} !== {1'b0, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL stop_at_terminal: busy=%b done=%b count=%0d expected busy=0 done=0 count=2", busy, done, count);
    end
  endtask

  task automatic test_cfg_lock();
    write_cfg(8'd4, 1'b0);
    do_start();
    cfg_we    = 1'b1;
    cfg_limit = 8'd9;
    cfg_mode  = 1'b1;
    step();
    cfg_we    = 1'b0;
    repeat (3) step();
    checks++;
    if ({busy, done, count} !== {1'b1, 1'b0, 8'd4}) begin
      errors++;
      $display("FAIL lock_at_4: busy=%b done=%b count=%0d expected busy=1 done=0 count=4", busy, done, count);
    end
    step();
    checks++;
    if ({busy, done, count} !== {1'b0, 1'b1, 8'd4}) begin
      errors++;
      $display("FAIL lock_done: busy=%b done=%b count=%0d expected busy=0 done=1 count=4", busy, done, count);
    end
    write_cfg(8'd9, 1'b0);
    do_start();
    repeat (9) step();
    checks++;
    if ({busy, done, count} !== {1'b1, 1'b0, 8'd9}) begin
      errors++;
      $display("FAIL relimit_at_9: busy=%b done=%b count=%0d expected busy=1 done=0 count=9", busy, done, count);
    end
    step();
    checks++;
    if ({busy, done, count} !== {1'b0, 1'b1, 8'd9}) begin
      errors++;
      $display("FAIL relimit_done: busy=%b done=%b count=%0d expected busy=0 done=1 count=9", busy, done, count);
    end
  endtask

  task automatic test_limit_zero();
    write_cfg(8'd0, 1'b1);
    do_start();
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if ({busy, done, count} !== {1'b1, 1'b1, 8'd0}) begin
        errors++;
        $display("FAIL zero_reload k=%0d: busy=%b done=%b count=%0d expected busy=1 done=1 count=0", k, busy, done, count);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    write_cfg(8'd0, 1'b0);
    do_start();
    step();
    checks++;
    if ({busy, done, count} !== {1'b0, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL zero_oneshot: busy=%b done=%b count=%0d expected busy=0 done=1 count=0", busy, done, count);
    end
  endtask

  task automatic test_async_reset();
    int seen_done;
    write_cfg(8'd20, 1'b0);
    do_start();
    repeat (7) step();
    checks++;
    if (count !== 8'd7) begin
      errors++;
      $display("FAIL areset_pre: count=%0d expected 7", count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, count} !== {1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL areset_immediate: busy=%b done=%b count=%0d expected busy=0 done=0 count=0", busy, done, count);
    end
    seen_done = 0;
    repeat (3) begin
      step();
      if (done) seen_done++;
    end
    checks++;
    if (seen_done !== 0) begin
      errors++;
      $display("FAIL areset_no_done: done pulses=%0d expected 0", seen_done);
    end
    #3 rst_n = 1'b1;
    step();
    write_cfg(8'd1, 1'b0);
    do_start();
    step();
    step();
    checks++;
    if ({busy, done, count} !== {1'b0, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL areset_recover: busy=%b done=%b count=%0d expected busy=0 done=1 count=1", busy, done, count);
    end
  endtask

`ifdef CONTADOR_CTRL_PRESCALE_EN
  task automatic test_prescale();
    logic [WIDTH-1:0] exp_cnt [1:6];
    exp_cnt = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
    cfg_presc = 4'd2;
    write_cfg(8'd1, 1'b0);
    cfg_presc = 4'd0;
    do_start();
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if ({busy, done, count} !== {(k != 6), (k == 6), exp_cnt[k]}) begin
        errors++;
        $display("FAIL presc k=%0d: busy=%b done=%b count=%0d expected busy=%b done=%b count=%0d",
                 k, busy, done, count, (k != 6), (k == 6), exp_cnt[k]);
      end
    end
  endtask
`endif

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_we    = 1'b0;
    cfg_limit = '0;
    cfg_mode  = 1'b0;
`ifdef CONTADOR_CTRL_PRESCALE_EN
    cfg_presc = '0;
`endif
    #1;
    test_reset();
    test_oneshot();
    test_reload();
    test_stop_priority();
    test_cfg_lock();
    test_limit_zero();
    test_async_reset();
`ifdef CONTADOR_CTRL_PRESCALE_EN
    test_prescale();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
